// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, and a
// start/wait/drain handshake that freezes the pipe while a custom IP runs.
module pipe_ctrl #(
   parameter int IP_TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        MemRead_EX,
   input  logic [4:0]  rd_EX,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        BranchTaken_EX,
   input  logic        IPOp_EX,
   input  logic        ip_done,
   output logic        stall_IF,
   output logic        stall_IFID,
   output logic        stall_IDEX,
   output logic        stall_EXMEM,
   output logic        flush_IFID,
   output logic        flush_IDEX,
   output logic        flush_MEMWB,
   output logic        ip_start,
   output logic        ip_capture,
   output logic        ip_timeout,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_IP_START = 2'b01,
      S_IP_WAIT  = 2'b10,
      S_IP_DRAIN = 2'b11
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(IP_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next_state;
   state_t      w_dec_state;
   logic        r_pending;
   logic        r_timeout;
   logic [15:0] r_wait_cnt;
   logic [15:0] r_stall_cnt;
   logic        w_load_use;
   logic        w_done;
   logic        w_expire;

   assign w_load_use = MemRead_EX && (rd_EX != 5'd0) &&
                       ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
   assign w_done     = r_pending || ip_done;
   assign w_expire   = (r_wait_cnt == TIMEOUT_LAST) && !w_done;
   // While reset is held the stall/flush decode behaves as if already in RUN.
   assign w_dec_state = RSTN ? r_state : S_RUN;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_RUN:      if (IPOp_EX) w_next_state = S_IP_START;
         S_IP_START: w_next_state = S_IP_WAIT;
         S_IP_WAIT:  if (w_done || w_expire) w_next_state = S_IP_DRAIN;
         S_IP_DRAIN: w_next_state = S_RUN;
         default:    w_next_state = S_RUN;
      endcase
   end

   always_comb begin
      stall_IF    = 1'b0;
      stall_IFID  = 1'b0;
      stall_IDEX  = 1'b0;
      stall_EXMEM = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEX  = 1'b0;
      flush_MEMWB = 1'b0;
      ip_start    = (r_state == S_IP_START);
      ip_capture  = (r_state == S_IP_DRAIN);
      case (w_dec_state)
         S_RUN: begin
            if (IPOp_EX) begin
               stall_IF    = 1'b1;
               stall_IFID  = 1'b1;
               stall_IDEX  = 1'b1;
               stall_EXMEM = 1'b1;
               flush_MEMWB = 1'b1;
            end else if (BranchTaken_EX) begin
               flush_IFID = 1'b1;
               flush_IDEX = 1'b1;
            end else if (w_load_use) begin
               stall_IF   = 1'b1;
               stall_IFID = 1'b1;
               flush_IDEX = 1'b1;
            end
         end
         S_IP_START, S_IP_WAIT: begin
            stall_IF    = 1'b1;
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            stall_EXMEM = 1'b1;
            flush_MEMWB = 1'b1;
         end
         default: ;
      endcase
   end

   // A done pulse that lands in IP_START is remembered so IP_WAIT lasts one cycle.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_pending   <= 1'b0;
         r_timeout   <= 1'b0;
         r_wait_cnt  <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (r_state == S_IP_START) begin
            r_wait_cnt <= 16'd0;
            r_pending  <= ip_done;
         end else if (r_state == S_IP_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            r_pending  <= 1'b0;
            if (w_expire) r_timeout <= 1'b1;
         end
         if (stall_IF && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign ip_timeout = r_timeout;
   assign state      = r_state;
   assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected output
// vector and stall count, which are popped and compared at the falling edge.
module tb_pipe_ctrl;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        MemRead_EX;
   logic [4:0]  rd_EX;
   logic [4:0]  rs1_ID;
   logic [4:0]  rs2_ID;
   logic        BranchTaken_EX;
   logic        IPOp_EX;
   logic        ip_done;
   logic        stall_IF, stall_IFID, stall_IDEX, stall_EXMEM;
   logic        flush_IFID, flush_IDEX, flush_MEMWB;
   logic        ip_start, ip_capture, ip_timeout;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   pipe_ctrl #(.IP_TIMEOUT(4)) dut (
      .CLK(CLK), .RSTN(RSTN), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .BranchTaken_EX(BranchTaken_EX),
      .IPOp_EX(IPOp_EX), .ip_done(ip_done),
      .stall_IF(stall_IF), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
      .stall_EXMEM(stall_EXMEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
      .flush_MEMWB(flush_MEMWB), .ip_start(ip_start), .ip_capture(ip_capture),
      .ip_timeout(ip_timeout), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   // {stall_IF,IFID,IDEX,EXMEM, flush_IFID,IDEX,MEMWB, ip_start, ip_capture, ip_timeout, state}
   localparam logic [11:0] E_IDLE  = 12'h000;
   localparam logic [11:0] E_LU    = 12'hC40;
   localparam logic [11:0] E_BR    = 12'h0C0;
   localparam logic [11:0] E_IPRUN = 12'hF20;
   localparam logic [11:0] E_START = 12'hF31;
   localparam logic [11:0] E_WAIT  = 12'hF22;
   localparam logic [11:0] E_DRAIN = 12'h00B;
   localparam logic [11:0] TO      = 12'h004;

   typedef struct {
      logic [11:0] vec;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [11:0] obs;
   logic [15:0] exp_cnt = 16'd0;
   logic        last_rstn = 1'b0;
   logic        last_sif = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   assign obs = {stall_IF, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID,
                 flush_IDEX, flush_MEMWB, ip_start, ip_capture, ip_timeout, state};

   task automatic drive(input logic rstn, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                        input logic ipop, input logic done, input logic [11:0] ev);
      exp_t x;
      @(posedge CLK);
      if (!last_rstn) exp_cnt = 16'd0;
      else if (last_sif && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      #1;
      RSTN = rstn; MemRead_EX = mr; rd_EX = rd; rs1_ID = rs1; rs2_ID = rs2;
      BranchTaken_EX = br; IPOp_EX = ipop; ip_done = done;
      last_rstn = rstn;
      last_sif  = ev[11];
      x.vec = ev;
      x.cnt = exp_cnt;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      logic [11:0] ev [4];
      ev = '{E_IDLE, E_LU, E_IPRUN, E_IDLE};
      for (int i = 0; i < 4; i++) begin
         drive(i == 3, i == 1, (i == 1) ? 5'd5 : 5'd0, 5'd0, (i == 1) ? 5'd5 : 5'd0,
               1'b0, i == 2, 1'b0, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL reset[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL reset[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_load_use();
      logic        mr  [6];
      logic [4:0]  rd  [6];
      logic [4:0]  rs1 [6];
      logic [4:0]  rs2 [6];
      logic [11:0] ev  [6];
      mr  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      rd  = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd0, 5'd5};
      rs1 = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd6};
      rs2 = '{5'd5, 5'd0, 5'd3, 5'd0, 5'd0, 5'd7};
      ev  = '{E_LU, E_IDLE, E_LU, E_IDLE, E_IDLE, E_IDLE};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, mr[i], rd[i], rs1[i], rs2[i], 1'b0, 1'b0, 1'b0, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL load_use[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL load_use[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_branch();
      logic        mr [3];
      logic        br [3];
      logic [11:0] ev [3];
      mr = '{1'b1, 1'b0, 1'b1};
      br = '{1'b1, 1'b1, 1'b0};
      ev = '{E_BR, E_BR, E_LU};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mr[i], mr[i] ? 5'd5 : 5'd0, 5'd0, mr[i] ? 5'd5 : 5'd0,
               br[i], 1'b0, 1'b0, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL branch[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL branch[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_done_in_start();
      logic [11:0] ev [5];
      ev = '{E_IPRUN, E_START, E_WAIT, E_DRAIN, E_IDLE};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, i == 0, i == 1, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL done_in_start[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL done_in_start[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_ip_op();
      logic [11:0] ev [7];
      ev = '{E_IPRUN, E_START, E_WAIT, E_WAIT, E_WAIT, E_DRAIN, E_IDLE};
      for (int i = 0; i < 7; i++) begin
         // Branch and load-use on the IP cycle are ignored; done in DRAIN/RUN is dropped.
         drive(1'b1, i == 0, (i == 0) ? 5'd5 : 5'd0, 5'd0, (i == 0) ? 5'd5 : 5'd0,
               i == 0, i == 0, i >= 4, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL ip_op[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL ip_op[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_timeout();
      logic [11:0] ev [14];
      ev = '{E_IPRUN, E_START, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_DRAIN | TO, E_IDLE | TO,
             E_IPRUN | TO, E_START | TO, E_WAIT | TO, E_WAIT | TO, E_DRAIN | TO, E_IDLE | TO};
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 0) || (i == 8),
               (i == 6) || (i == 7) || (i == 11), ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL timeout[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL timeout[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      logic [11:0] ev [6];
      ev = '{E_IPRUN | TO, E_START | TO, E_WAIT | TO, E_IPRUN | TO | 12'h002, E_IDLE, E_IDLE};
      for (int i = 0; i < 6; i++) begin
         drive(i != 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 0) || (i == 3), 1'b0, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL reset_in_wait[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL reset_in_wait[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_done_final();
      logic [11:0] ev [8];
      ev = '{E_IPRUN, E_START, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_DRAIN, E_IDLE};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, i == 0, i == 5, ev[i]);
         @(negedge CLK);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e.vec) begin
            n_errors++;
            $display("FAIL done_final[%0d] outputs: got %03h expected %03h", i, obs, e.vec);
         end
         n_checks++;
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL done_final[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
         end
      end
   endtask

   initial begin
      RSTN = 1'b0; MemRead_EX = 1'b0; rd_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
      BranchTaken_EX = 1'b0; IPOp_EX = 1'b0; ip_done = 1'b0;
      repeat (2) @(posedge CLK);
      test_reset();
      test_load_use();
      test_branch();
      test_done_in_start();
      test_ip_op();
      test_timeout();
      test_reset_in_wait();
      test_done_final();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL provide parameter IP_TIMEOUT, default 64, maximum cycles spent in IP_WAIT before abort; legal range 2..65535.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low; the ports are named CLK and RSTN.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RSTN  in  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-005 MemRead_EX  in  1  load instruction occupies EX.
REQ-006 rd_EX  in  5  destination register of EX instruction.
REQ-007 rs1_ID, rs2_ID  in  5 each  source registers of ID instruction.
REQ-008 BranchTaken_EX  in  1  taken branch/jump resolved in EX.
REQ-009 IPOp_EX  in  1  custom-IP instruction occupies EX.
REQ-010 ip_done  in  1  custom IP result valid, single-cycle pulse.
REQ-011 stall_IF, stall_IFID, stall_IDEX, stall_EXMEM  out  1 each  hold the corresponding PC/pipeline register.
REQ-012 flush_IFID, flush_IDEX, flush_MEMWB  out  1 each  load a bubble into the corresponding pipeline register.
REQ-013 ip_start  out  1  registered one-cycle start pulse to the custom IP.
REQ-014 ip_capture  out  1  EX stage latches the IP result this cycle.
REQ-015 ip_timeout  out  1  sticky abort flag.
REQ-016 state  out  2  FSM state: RUN=00, IP_START=01, IP_WAIT=10, IP_DRAIN=11.
REQ-017 stall_cnt  out  16  saturating count of cycles with stall_IF=1.

Function
REQ-018 Load-use hazard SHALL be MemRead_EX & (rd_EX!=0) & (rd_EX==rs1_ID | rd_EX==rs2_ID).
REQ-019 In RUN with IPOp_EX=0 and BranchTaken_EX=1: flush_IFID=1, flush_IDEX=1, all stalls 0, regardless of load-use.
REQ-020 In RUN with IPOp_EX=0, BranchTaken_EX=0 and load-use: stall_IF=1, stall_IFID=1, flush_IDEX=1, others 0.
REQ-021 In RUN with IPOp_EX=1: stall_IF, stall_IFID, stall_IDEX, stall_EXMEM=1, flush_MEMWB=1, all other flushes 0; BranchTaken_EX and load-use ignored; next state IP_START.
REQ-022 In RUN with no condition above, all stall/flush outputs SHALL be 0 and state stays RUN.
REQ-023 Stall/flush outputs SHALL be combinational from state and current inputs; ip_start and ip_capture SHALL be registered (driven by state).
REQ-024 IP_START: ip_start=1 for exactly this cycle; the four stalls=1, flush_MEMWB=1; timeout counter cleared; next state IP_WAIT.
REQ-025 ip_done asserted during IP_START SHALL be latched into a pending bit; in IP_WAIT, pending or ip_done -> IP_DRAIN next cycle, pending cleared.
REQ-026 IP_WAIT: the four stalls=1, flush_MEMWB=1; 16-bit counter increments each cycle.
REQ-027 IP_WAIT with counter==IP_TIMEOUT-1 and no done: ip_timeout set, next state IP_DRAIN; done on the same cycle takes priority (no timeout).
REQ-028 IP_DRAIN: ip_capture=1, all stalls 0, all flushes 0, one cycle, next state RUN.
REQ-029 ip_done in RUN, IP_DRAIN or after timeout SHALL be ignored and not latched.
REQ-030 ip_timeout SHALL remain 1 until reset.
REQ-031 stall_cnt increments every cycle stall_IF=1 and saturates at 16'hFFFF.
REQ-032 The IP op SHALL yield exactly IP_START + N IP_WAIT + 1 IP_DRAIN cycles, N>=1.

Reset
REQ-033 RSTN=0 at a rising edge SHALL set state=RUN, ip_start=0, ip_capture=0, ip_timeout=0, pending=0, counter=0, stall_cnt=0.
REQ-034 Reset during IP_START/IP_WAIT/IP_DRAIN SHALL abort the operation with no further ip_start or ip_capture pulse.
REQ-035 During reset, combinational outputs SHALL reflect the RUN decode of current inputs.

Verification
REQ-036 MemRead_EX=1, rd_EX=5, rs2_ID=5 in RUN -> stall_IF=stall_IFID=flush_IDEX=1 same cycle; stall_cnt 0->1.
REQ-037 Same load-use plus BranchTaken_EX=1 -> flush_IFID=flush_IDEX=1, stall_IF=0; rd_EX=0 with rs1_ID=0 -> no stall.
REQ-038 IPOp_EX=1, ip_done 3 cycles after ip_start -> states 00,01,10,10,10,11,00; ip_start one pulse; ip_capture one pulse; stall_cnt=5.
REQ-039 IP_TIMEOUT=4, no ip_done -> exactly 4 IP_WAIT cycles, ip_timeout=1 and stays 1 through a subsequent IP op.
REQ-040 ip_done in IP_START cycle -> exactly one IP_WAIT cycle, then IP_DRAIN; ip_done on the final timeout cycle -> ip_timeout stays 0.
REQ-041 RSTN=0 for one cycle in IP_WAIT -> state=00 next cycle, no ip_capture, stall_cnt=0, ip_timeout=0.
